// File: rtl/uart_rx.sv
// uart_rx -- oversampled UART receiver (RX clock domain).
//
// Recovers frames of: start bit, DATA_WIDTH data bits (LSB first), optional
// parity bit, one stop bit. Each bit lasts Prescale clocks (legal: 8/16/32).
// Frame settings (Prescale, Par_En, Par_Typ) are latched at the start edge
// and govern the whole frame.
//
// Ports:
//   CLK        oversampling clock (Prescale x bit rate)
//   rst_n      asynchronous active-low reset
//   RX_IN      serial line, idles high, already synchronised
//   Prescale   oversampling ratio
//   Par_En     1 = parity bit present
//   Par_Typ    0 = even parity, 1 = odd parity
//   P_DATA     last correctly received byte (held between frames)
//   Data_Valid one-cycle strobe: P_DATA is new
//   Par_Err    one-cycle strobe: parity mismatch
//   Stp_Err    one-cycle strobe: stop bit sampled low
//
// Build option: define UART_RX_MAJORITY_EN to take a 2-of-3 majority over
// edges Prescale/2-1, Prescale/2, Prescale/2+1 instead of a single sample at
// Prescale/2. Strobes then arrive one clock later.
module uart_rx #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      rst_n,
  input  logic                      RX_IN,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  input  logic                      Par_En,
  input  logic                      Par_Typ,
  output logic [DATA_WIDTH-1:0]     P_DATA,
  output logic                      Data_Valid,
  output logic                      Par_Err,
  output logic                      Stp_Err
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [PRESCALE_WIDTH-1:0] ONE      = 1;
  localparam logic [BIT_W-1:0]          LAST_BIT = BIT_W'(DATA_WIDTH - 1);

  logic [2:0]                state;
  logic [PRESCALE_WIDTH-1:0] edge_cnt;
  logic [BIT_W-1:0]          bit_cnt;
  logic [PRESCALE_WIDTH-1:0] presc_q;
  logic                      par_en_q;
  logic                      par_typ_q;
  logic                      par_err_q;
  logic [DATA_WIDTH-1:0]     shift_q;

  logic [PRESCALE_WIDTH-1:0] half;
  logic [PRESCALE_WIDTH-1:0] dec_edge;
  logic                      bit_next;
  logic                      dec_now;
  logic                      bit_end;
  logic                      exp_par;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  assign half = presc_q >> 1;

`ifdef UART_RX_MAJORITY_EN
  logic samp_a;
  logic samp_b;

  // Early samples; the third one is RX_IN itself on the decision edge.
  always_ff @(posedge CLK) begin
    if (edge_cnt == half - ONE) samp_a <= RX_IN;
    if (edge_cnt == half)       samp_b <= RX_IN;
  end

  assign dec_edge = half + ONE;
  assign bit_next = majority3(samp_a, samp_b, RX_IN);
`else
  assign dec_edge = half;
  assign bit_next = RX_IN;
`endif

  // dec_now marks the clock edge on which the bit decision (bit_next) is
  // captured; everything that consumes the decision acts on that same edge,
  // so the result is visible from the following edge onwards.
  assign dec_now = (state != IDLE) && (edge_cnt == dec_edge);
  assign bit_end = (edge_cnt == presc_q - ONE);
  assign exp_par = par_typ_q ? ~^shift_q : ^shift_q;

  // Received data bits; never exposed until a clean frame completes.
  always_ff @(posedge CLK) begin
    if (state == DATA && dec_now) shift_q[bit_cnt] <= bit_next;
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      edge_cnt   <= '0;
      bit_cnt    <= '0;
      presc_q    <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      par_err_q  <= 1'b0;
      P_DATA     <= '0;
      Data_Valid <= 1'b0;
      Par_Err    <= 1'b0;
      Stp_Err    <= 1'b0;
    end else begin
      Data_Valid <= 1'b0;
      Par_Err    <= 1'b0;
      Stp_Err    <= 1'b0;

      if (state != IDLE) begin
        if (bit_end) edge_cnt <= '0;
        else         edge_cnt <= edge_cnt + ONE;
      end

      case (state)
        IDLE: begin
          edge_cnt <= '0;
          bit_cnt  <= '0;
          if (!RX_IN) begin
            // This cycle is edge 0 of the start bit.
            state     <= START;
            edge_cnt  <= ONE;
            presc_q   <= Prescale;
            par_en_q  <= Par_En;
            par_typ_q <= Par_Typ;
            par_err_q <= 1'b0;
          end
        end
        START: begin
          if (dec_now && bit_next) begin
            state    <= IDLE;
            edge_cnt <= '0;
          end else if (bit_end) begin
            state <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              state   <= par_en_q ? PARITY : STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        PARITY: begin
          if (dec_now) par_err_q <= (bit_next != exp_par);
          if (bit_end) state <= STOP;
        end
        STOP: begin
          // Leave without waiting for the end of the stop bit so a frame
          // that follows immediately is still caught at its start edge.
          if (dec_now) begin
            state    <= IDLE;
            edge_cnt <= '0;
            Par_Err  <= par_err_q;
            Stp_Err  <= ~bit_next;
            if (!par_err_q && bit_next) begin
              Data_Valid <= 1'b1;
              P_DATA     <= shift_q;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx -- self-checking bench for uart_rx.
// Frames are driven bit by bit; a frame-level model predicts, for each frame,
// the strobe pattern, the P_DATA value and the cycle on which strobes appear.
// A monitor records every cycle with any strobe high; recorded and predicted
// events are compared after each test section.
module tb_uart_rx;

  logic       CLK = 1'b0;
  logic       rst_n = 1'b0;
  logic       RX_IN = 1'b1;
  logic [5:0] Prescale = 6'd16;
  logic       Par_En = 1'b0;
  logic       Par_Typ = 1'b0;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       Par_Err;
  logic       Stp_Err;

`ifdef UART_RX_MAJORITY_EN
  localparam int DEC_LAG = 2;
`else
  localparam int DEC_LAG = 1;
`endif

  uart_rx #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
    .CLK(CLK), .rst_n(rst_n), .RX_IN(RX_IN), .Prescale(Prescale),
    .Par_En(Par_En), .Par_Typ(Par_Typ), .P_DATA(P_DATA),
    .Data_Valid(Data_Valid), .Par_Err(Par_Err), .Stp_Err(Stp_Err)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic       dv;
    logic       pe;
    logic       se;
    logic [7:0] pd;
  } ev_t;

  ev_t got_q[$];
  ev_t exp_q[$];

  always @(negedge CLK) begin
    ev_t e;
    if (Data_Valid === 1'b1 || Par_Err === 1'b1 || Stp_Err === 1'b1) begin
      e.cyc = cyc; e.dv = Data_Valid; e.pe = Par_Err; e.se = Stp_Err; e.pd = P_DATA;
      got_q.push_back(e);
    end
  end

  int         errors = 0;
  int         checks = 0;
  logic [7:0] model_pd = 8'h00;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic logic [5:0] legal_presc();
    return 6'(8 << $urandom_range(0, 2));
  endfunction

  // Drives one frame starting at #1 after a posedge; returns at #1 after the
  // posedge that ends the stop bit. abort_at >= 0 pulses reset mid-bit.
  task automatic send_frame(input logic [7:0] d, input int presc, input logic pen,
                            input logic ptyp, input logic pbit, input logic stop,
                            input int abort_at);
    logic [10:0] bits;
    int          nb;
    int          c0;
    logic        good_par;
    ev_t         e;
    bits = '0;
    bits[8:1] = d;
    if (pen) begin bits[9] = pbit; bits[10] = stop; nb = 11; end
    else     begin bits[9] = stop; nb = 10; end
    c0 = cyc;
    Prescale = 6'(presc); Par_En = pen; Par_Typ = ptyp;
    for (int i = 0; i < nb; i++) begin
      RX_IN = bits[i];
      if (i == abort_at) begin
        repeat (presc / 2) @(posedge CLK);
        #1;
        rst_n = 1'b0; RX_IN = 1'b1; model_pd = 8'h00;
        repeat (2) @(posedge CLK);
        #1;
        rst_n = 1'b1;
        return;
      end
      repeat (presc) @(posedge CLK);
      #1;
      if (i == 0) begin
        // Mid-frame input changes must not affect this frame.
        Prescale = legal_presc(); Par_En = 1'($urandom); Par_Typ = 1'($urandom);
      end
    end
    RX_IN = 1'b1;
    good_par = ptyp ? ~^d : ^d;
    e.pe  = pen && (pbit != good_par);
    e.se  = !stop;
    e.dv  = !e.pe && stop;
    if (e.dv) model_pd = d;
    e.pd  = model_pd;
    e.cyc = c0 + (nb - 1) * presc + presc / 2 + DEC_LAG;
    exp_q.push_back(e);
  endtask

  task automatic check_events(input string tag);
    int n;
    repeat (20) @(posedge CLK);
    #1;
    chk({tag, "_event_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_ev%0d_cycle", tag, i), got_q[i].cyc, exp_q[i].cyc);
      chk($sformatf("%s_ev%0d_dv", tag, i), got_q[i].dv, exp_q[i].dv);
      chk($sformatf("%s_ev%0d_pe", tag, i), got_q[i].pe, exp_q[i].pe);
      chk($sformatf("%s_ev%0d_se", tag, i), got_q[i].se, exp_q[i].se);
      chk($sformatf("%s_ev%0d_pdata", tag, i), got_q[i].pd, exp_q[i].pd);
    end
    chk({tag, "_pdata_hold"}, P_DATA, model_pd);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_pdata", P_DATA, 8'h00);
    chk("rst_dv", Data_Valid, 1'b0);
    chk("rst_pe", Par_Err, 1'b0);
    chk("rst_se", Stp_Err, 1'b0);
    rst_n = 1'b1;
    repeat (4) @(posedge CLK);
    #1;

    // Odd parity, correct parity bit
    send_frame(8'hA5, 32, 1'b1, 1'b1, 1'b1, 1'b1, -1);
    check_events("odd_ok");

    // Even parity, wrong parity bit: P_DATA holds 0xA5
    send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b1, -1);
    check_events("par_err");

    // No parity, stop bit low
    send_frame(8'hFF, 8, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    check_events("stop_err");

    // Start glitch then a clean frame
    Prescale = 6'd16; Par_En = 1'b0;
    RX_IN = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    RX_IN = 1'b1;
    repeat (40) @(posedge CLK);
    #1;
    send_frame(8'h55, 16, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    check_events("glitch");

    // Back-to-back frames
    send_frame(8'h01, 32, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    send_frame(8'h80, 32, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    send_frame(8'h7E, 32, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    check_events("b2b");

    // Reset during data bit 4
    send_frame(8'hC3, 32, 1'b0, 1'b0, 1'b0, 1'b1, 5);
    check_events("abort");
    chk("abort_pdata_zero", P_DATA, 8'h00);
    send_frame(8'h12, 32, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    check_events("after_abort");

    // Random frames with random settings, errors and gaps
    for (int k = 0; k < 16; k++) begin
      logic [7:0] d;
      logic       pen, ptyp, pbit, stop;
      int         presc, gap;
      d     = 8'($urandom);
      presc = int'(legal_presc());
      pen   = 1'($urandom);
      ptyp  = 1'($urandom);
      pbit  = ptyp ? ~^d : ^d;
      if ($urandom_range(0, 4) == 0) pbit = ~pbit;
      stop  = ($urandom_range(0, 5) != 0);
      gap   = $urandom_range(0, 3);
      send_frame(d, presc, pen, ptyp, pbit, stop, -1);
      repeat (gap) @(posedge CLK);
      #1;
    end
    check_events("random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
